nav_drive_ramp: RTL and testbench
=================================

# nav_drive_ramp

Parametrised two-side drive command generator for the navigation system. It replaces the fixed button-to-motor-controller mapping with ramped power, so power steps toward the switch setting at a programmable rate. It forces a ramp-down and neutral dwell before any direction reversal. It sits between the debounced user inputs (buttons, power switches) and the two motor-controller command buses MC1 (left) and MC2 (right).

## Interface
- PW, 3: power field width in bits.
- RAMP_DIV, 50000: clock cycles per ramp step; must be ≥1.
- DWELL, 1000: neutral dwell length in cycles before a reversal completes; must be ≥1.

- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- BTN  input  5  direction buttons: [4] neutral, [3] left, [2] forward, [1] reverse, [0] right. Synchronous to CLK, debounced upstream.
- PWR_L  input  PW  target power for MC1.
- PWR_R  input  PW  target power for MC2.
- MC1  output  PW+2  left command: [PW+1:2] power, [1:0] direction (00 fwd, 01 neutral, 10 rev).
- MC2  output  PW+2  right command, same encoding.
- BUSY  output  1  high while either side is in DECEL or DWELL.

## Operation
- Decode (combinational, every cycle):
  - BTN[4]=1 → both sides neutral.
  - 00100 → both fwd.
  - 00010 → both rev.
  - 01000 → MC1 fwd, MC2 neutral.
  - 00001 → MC1 neutral, MC2 fwd.
  - Any other value → both neutral.
- Per-side requested direction is req_dir. Target power is PWR_x when req_dir ≠ neutral, otherwise 0.
- Shared prescaler counts 0..RAMP_DIV-1 and wraps. tick=1 in the cycle where count = RAMP_DIV-1.
- Each side has an independent FSM {RUN, DECEL, DWELL}, with registers cur_dir, pwr, and dwell count.
- RUN:
  - req_dir = cur_dir: on tick, pwr moves by exactly 1 toward the target; hold if equal. The target is re-sampled every tick, so a mid-ramp switch change retargets.
  - req_dir ≠ cur_dir and cur_dir = neutral: cur_dir ← req_dir next cycle, stay in RUN (pwr is 0).
  - req_dir ≠ cur_dir and cur_dir ≠ neutral: go to DECEL.
- DECEL:
  - On tick, pwr decrements by 1 (never below 0). cur_dir output is unchanged.
  - If req_dir returns to cur_dir: go to RUN, and ramping resumes toward the target from the present pwr.
  - When pwr = 0 and req_dir = neutral: cur_dir ← neutral, go to RUN with no dwell.
  - When pwr = 0 and req_dir is the opposite non-neutral direction: cur_dir ← neutral, clear the dwell count, go to DWELL.
- DWELL:
  - Direction output is neutral and pwr is 0. The dwell count increments every cycle; BTN changes are ignored until exit.
  - At count = DWELL-1: cur_dir ← req_dir sampled in that cycle, go to RUN. If req_dir is neutral at exit, the side is simply neutral.
- Outputs: MC = {pwr, cur_dir}, registered directly from the FSM registers with no extra stage.
- BUSY = OR over both sides of (state ≠ RUN), registered.

## Timing
- Reset values, asserted asynchronously on RST rise:
  - MC1 = MC2 = {PW'b0, 2'b01}.
  - BUSY = 0, both FSMs in RUN, prescaler 0, dwell counts 0.
- Release of RST is synchronous; the first active edge follows deassertion.
- BTN to direction change from neutral: 1 cycle.
- Ramp: a full-scale change from 0 to V takes V ticks, i.e. V·RAMP_DIV cycles worst case from the first tick.
- Reversal from power P: about P ticks of DECEL, then DWELL cycles of neutral, then the new direction.
- Power never changes in a cycle without tick. Direction never goes fwd↔rev without an intervening neutral of DWELL cycles.
- Power is 0 in any cycle where direction is neutral.
- RAMP_DIV=1 gives a tick every cycle. A tick coinciding with a DECEL→RUN abort applies the RUN step rule in that cycle.

## Test plan
Parameters for all scenarios: PW=3, RAMP_DIV=4, DWELL=8.
1. Reset mid-ramp (MC1 power 4, fwd), then assert RST → same cycle MC1=MC2=5'b00001, BUSY=0. After release, hold neutral until a button is pressed.
2. Start from neutral, BTN=00100, PWR_L=5, PWR_R=7 → both dirs 00 after 1 cycle; power rises 1 per 4 cycles. MC1 holds at 5 after 5 ticks; MC2 holds at 7 after 7 ticks.
3. At fwd power 7/7, BTN=00010 → BUSY=1; power falls to 0 over 7 ticks with dir 00. Then dir 01 for exactly 8 cycles, then dir 10, ramp back to 7, BUSY=0.
4. During DECEL at power 3, BTN returns to 00100 → state RUN, dir stays 00 with no neutral, power climbs 3→7.
5. Left turn from fwd 7/7 (BTN=01000) → MC1 stays 00 at 7; MC2 decels to 0, then shows 01 with no dwell. BUSY drops as soon as MC2 reaches 0.
6. BTN=00110, then 11111 → both sides decel to 0, then neutral 01. PWR changes during neutral leave power at 0.

Source files
------------

// File: rtl/nav_drive_ramp.sv
// nav_drive_ramp: two-side drive command generator.
// Each side ramps its power toward the switch setting, one step per prescaler tick. A direction
// reversal always goes through a ramp-down to zero and then a neutral dwell before the new
// direction is applied.
module nav_drive_ramp #(
   parameter int unsigned PW       = 3,
   parameter int unsigned RAMP_DIV = 50000,
   parameter int unsigned DWELL    = 1000
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [4:0]    BTN,
   input  logic [PW-1:0] PWR_L,
   input  logic [PW-1:0] PWR_R,
   output logic [PW+1:0] MC1,
   output logic [PW+1:0] MC2,
   output logic          BUSY
);

   localparam int unsigned PreW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(RAMP_DIV - 1);
   localparam logic [DwW-1:0]  DwMax  = DwW'(DWELL - 1);

   localparam logic [1:0] DirFwd = 2'b00;
   localparam logic [1:0] DirNeu = 2'b01;
   localparam logic [1:0] DirRev = 2'b10;

   typedef enum logic [1:0] {StRun, StDecel, StDwell} state_e;

   // Index 0 is the left side (MC1), index 1 the right side (MC2).
   logic [1:0]      req_dir [2];
   logic [PW-1:0]   pwr_in  [2];
   logic [PW-1:0]   tgt     [2];

   state_e          st_q    [2];
   state_e          st_d    [2];
   logic [1:0]      cur_q   [2];
   logic [1:0]      cur_d   [2];
   logic [PW-1:0]   pwr_q   [2];
   logic [PW-1:0]   pwr_d   [2];
   logic [DwW-1:0]  dw_q    [2];
   logic [DwW-1:0]  dw_d    [2];

   logic [PreW-1:0] pre_q;
   logic            tick;
   logic            busy_q;

   // One power step toward the target, holding when already there.
   function automatic logic [PW-1:0] step_toward(input logic [PW-1:0] cur,
                                                 input logic [PW-1:0] target);
      if (cur < target) begin
         return cur + PW'(1);
      end else if (cur > target) begin
         return cur - PW'(1);
      end
      return cur;
   endfunction

   // Shared ramp prescaler: tick marks the last count of each period.
   assign tick = (pre_q == PreMax);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PreW'(1);
      end
   end

   // Button decode; any pattern not listed (including BTN[4] set) means both sides neutral.
   always_comb begin
      req_dir[0] = DirNeu;
      req_dir[1] = DirNeu;
      case (BTN)
         5'b00100: begin
            req_dir[0] = DirFwd;
            req_dir[1] = DirFwd;
         end
         5'b00010: begin
            req_dir[0] = DirRev;
            req_dir[1] = DirRev;
         end
         5'b01000: req_dir[0] = DirFwd;
         5'b00001: req_dir[1] = DirFwd;
         default: ;
      endcase
   end

   // Per-side target power: the switch setting, or zero when the side is asked to be neutral.
   always_comb begin
      pwr_in[0] = PWR_L;
      pwr_in[1] = PWR_R;
      for (int s = 0; s < 2; s++) begin
         tgt[s] = (req_dir[s] == DirNeu) ? '0 : pwr_in[s];
      end
   end

   // Per-side next-state logic for the RUN / DECEL / DWELL machine.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         st_d[s]  = st_q[s];
         cur_d[s] = cur_q[s];
         pwr_d[s] = pwr_q[s];
         dw_d[s]  = dw_q[s];
         case (st_q[s])
            StRun: begin
               if (req_dir[s] == cur_q[s]) begin
                  if (tick) begin
                     pwr_d[s] = step_toward(pwr_q[s], tgt[s]);
                  end
               end else if (cur_q[s] == DirNeu) begin
                  // Power is already zero while neutral, so the new direction applies at once.
                  cur_d[s] = req_dir[s];
               end else begin
                  st_d[s] = StDecel;
               end
            end
            StDecel: begin
               if (req_dir[s] == cur_q[s]) begin
                  // Abort: resume ramping from the present power, stepping now if ticking.
                  st_d[s] = StRun;
                  if (tick) begin
                     pwr_d[s] = step_toward(pwr_q[s], tgt[s]);
                  end
               end else if (pwr_q[s] == '0) begin
                  cur_d[s] = DirNeu;
                  if (req_dir[s] == DirNeu) begin
                     st_d[s] = StRun;
                  end else begin
                     st_d[s] = StDwell;
                     dw_d[s] = '0;
                  end
               end else if (tick) begin
                  pwr_d[s] = pwr_q[s] - PW'(1);
               end
            end
            StDwell: begin
               // Buttons are only looked at on the final dwell cycle.
               if (dw_q[s] == DwMax) begin
                  cur_d[s] = req_dir[s];
                  st_d[s]  = StRun;
                  dw_d[s]  = '0;
               end else begin
                  dw_d[s] = dw_q[s] + DwW'(1);
               end
            end
            default: begin
               st_d[s]  = StRun;
               cur_d[s] = DirNeu;
               pwr_d[s] = '0;
               dw_d[s]  = '0;
            end
         endcase
      end
   end

   // Per-side state registers; these drive the command buses directly.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < 2; s++) begin
            st_q[s]  <= StRun;
            cur_q[s] <= DirNeu;
            pwr_q[s] <= '0;
            dw_q[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            st_q[s]  <= st_d[s];
            cur_q[s] <= cur_d[s];
            pwr_q[s] <= pwr_d[s];
            dw_q[s]  <= dw_d[s];
         end
      end
   end

   // BUSY is registered from the next state so it lines up with the state registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= (st_d[0] != StRun) || (st_d[1] != StRun);
      end
   end

   assign MC1  = {pwr_q[0], cur_q[0]};
   assign MC2  = {pwr_q[1], cur_q[1]};
   assign BUSY = busy_q;

   // Safety invariants of the drive outputs.
   for (genvar g = 0; g < 2; g++) begin : g_chk
      a_neutral_zero: assert property (@(posedge CLK) disable iff (RST)
         (cur_q[g] == DirNeu) |-> (pwr_q[g] == '0));
      a_no_direct_reverse: assert property (@(posedge CLK) disable iff (RST)
         (($past(cur_q[g]) != DirNeu) && (cur_q[g] != DirNeu)) |-> (cur_q[g] == $past(cur_q[g])));
      a_pwr_on_tick: assert property (@(posedge CLK) disable iff (RST)
         (pwr_q[g] != $past(pwr_q[g])) |-> $past(tick));
   end

endmodule

// File: tb/tb_nav_drive_ramp.sv
// Bench for nav_drive_ramp: directed vector table, async-reset sequence, and randomized run
// against a behavioural model.
module tb_nav_drive_ramp;

   localparam int PW = 3;
   localparam int RD = 4;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [4:0]    BTN;
   logic [PW-1:0] PWR_L;
   logic [PW-1:0] PWR_R;
   logic [PW+1:0] MC1;
   logic [PW+1:0] MC2;
   logic          BUSY;

   int checks = 0;
   int errors = 0;

   nav_drive_ramp #(
      .PW       (PW),
      .RAMP_DIV (RD),
      .DWELL    (DW)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .BTN   (BTN),
      .PWR_L (PWR_L),
      .PWR_R (PWR_R),
      .MC1   (MC1),
      .MC2   (MC2),
      .BUSY  (BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // Behavioural model: dir 0=fwd 1=neutral 2=rev; phase 0=normal 1=slowing 2=waiting.
   int m_dir [2];
   int m_p   [2];
   int m_ph  [2];
   int m_wait[2];
   int m_edges;

   function automatic int req_of(input logic [4:0] b, input int s);
      if (b == 5'b00100) return 0;
      if (b == 5'b00010) return 2;
      if (b == 5'b01000) return (s == 0) ? 0 : 1;
      if (b == 5'b00001) return (s == 1) ? 0 : 1;
      return 1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_dir[s] = 1; m_p[s] = 0; m_ph[s] = 0; m_wait[s] = 0;
      end
      m_edges = 0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      bit tk;
      int req, tgt, pin;
      tk = ((m_edges % RD) == RD - 1);
      for (int s = 0; s < 2; s++) begin
         req = req_of(BTN, s);
         pin = (s == 0) ? int'(PWR_L) : int'(PWR_R);
         tgt = (req == 1) ? 0 : pin;
         if (m_ph[s] == 2) begin
            m_wait[s]--;
            if (m_wait[s] == 0) begin
               m_dir[s] = req;
               m_ph[s]  = 0;
            end
         end else if (req == m_dir[s]) begin
            m_ph[s] = 0;
            if (tk) m_p[s] += (tgt > m_p[s]) ? 1 : ((tgt < m_p[s]) ? -1 : 0);
         end else if (m_ph[s] == 0) begin
            if (m_dir[s] == 1) m_dir[s] = req;
            else m_ph[s] = 1;
         end else if (m_p[s] == 0) begin
            m_dir[s] = 1;
            if (req == 1) m_ph[s] = 0;
            else begin
               m_ph[s]   = 2;
               m_wait[s] = DW;
            end
         end else if (tk) begin
            m_p[s]--;
         end
      end
      m_edges++;
   endtask

   function automatic logic [10:0] model_out();
      logic [4:0] a, b;
      a = 5'(m_p[0] * 4 + m_dir[0]);
      b = 5'(m_p[1] * 4 + m_dir[1]);
      return {a, b, ((m_ph[0] != 0) || (m_ph[1] != 0)) ? 1'b1 : 1'b0};
   endfunction

   // Leaves the bench at a falling edge with reset just released and all inputs zero.
   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; BTN = '0; PWR_L = '0; PWR_R = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      model_reset();
   endtask

   typedef struct packed {
      logic [4:0] btn;
      logic [2:0] pl;
      logic [2:0] pr;
      logic [7:0] cyc;
      logic [4:0] mc1;
      logic [4:0] mc2;
      logic       busy;
   } vec_t;

   vec_t tbl [29];

   initial begin
      logic [3:0] hold;
      logic [4:0] pick [8];

      // Cumulative edge count after reset noted per row; ticks fall on edges 4, 8, 12, ...
      tbl[0]  = '{5'b00100, 3'd5, 3'd7, 8'd1,  5'b00000, 5'b00000, 1'b0}; // E1 dir fwd
      tbl[1]  = '{5'b00100, 3'd5, 3'd7, 8'd2,  5'b00000, 5'b00000, 1'b0}; // E3 no tick yet
      tbl[2]  = '{5'b00100, 3'd5, 3'd7, 8'd1,  5'b00100, 5'b00100, 1'b0}; // E4 first step
      tbl[3]  = '{5'b00100, 3'd5, 3'd7, 8'd16, 5'b10100, 5'b10100, 1'b0}; // E20
      tbl[4]  = '{5'b00100, 3'd5, 3'd7, 8'd8,  5'b10100, 5'b11100, 1'b0}; // E28 both hold
      tbl[5]  = '{5'b00010, 3'd5, 3'd7, 8'd1,  5'b10100, 5'b11100, 1'b1}; // E29 decel
      tbl[6]  = '{5'b00010, 3'd5, 3'd7, 8'd3,  5'b10000, 5'b11000, 1'b1}; // E32
      tbl[7]  = '{5'b00010, 3'd5, 3'd7, 8'd16, 5'b00000, 5'b01000, 1'b1}; // E48
      tbl[8]  = '{5'b00010, 3'd5, 3'd7, 8'd1,  5'b00001, 5'b01000, 1'b1}; // E49 dwell
      tbl[9]  = '{5'b00010, 3'd5, 3'd7, 8'd7,  5'b00001, 5'b00000, 1'b1}; // E56
      tbl[10] = '{5'b00010, 3'd5, 3'd7, 8'd1,  5'b00010, 5'b00001, 1'b1}; // E57 rev
      tbl[11] = '{5'b00010, 3'd5, 3'd7, 8'd7,  5'b01010, 5'b00001, 1'b1}; // E64
      tbl[12] = '{5'b00010, 3'd5, 3'd7, 8'd1,  5'b01010, 5'b00010, 1'b0}; // E65
      tbl[13] = '{5'b00010, 3'd5, 3'd7, 8'd27, 5'b10110, 5'b11110, 1'b0}; // E92
      tbl[14] = '{5'b00100, 3'd5, 3'd7, 8'd8,  5'b01110, 5'b10110, 1'b1}; // E100
      tbl[15] = '{5'b00010, 3'd5, 3'd7, 8'd1,  5'b01110, 5'b10110, 1'b0}; // E101 abort
      tbl[16] = '{5'b00010, 3'd5, 3'd7, 8'd7,  5'b10110, 5'b11110, 1'b0}; // E108
      tbl[17] = '{5'b10000, 3'd5, 3'd7, 8'd20, 5'b00010, 5'b01010, 1'b1}; // E128
      tbl[18] = '{5'b10000, 3'd5, 3'd7, 8'd1,  5'b00001, 5'b01010, 1'b1}; // E129
      tbl[19] = '{5'b10000, 3'd5, 3'd7, 8'd7,  5'b00001, 5'b00010, 1'b1}; // E136
      tbl[20] = '{5'b10000, 3'd5, 3'd7, 8'd1,  5'b00001, 5'b00001, 1'b0}; // E137
      tbl[21] = '{5'b10000, 3'd2, 3'd6, 8'd8,  5'b00001, 5'b00001, 1'b0}; // E145
      tbl[22] = '{5'b00100, 3'd2, 3'd6, 8'd1,  5'b00000, 5'b00000, 1'b0}; // E146
      tbl[23] = '{5'b00100, 3'd2, 3'd6, 8'd22, 5'b01000, 5'b11000, 1'b0}; // E168
      tbl[24] = '{5'b01000, 3'd2, 3'd6, 8'd1,  5'b01000, 5'b11000, 1'b1}; // E169 left
      tbl[25] = '{5'b01000, 3'd2, 3'd6, 8'd23, 5'b01000, 5'b00000, 1'b1}; // E192
      tbl[26] = '{5'b01000, 3'd2, 3'd6, 8'd1,  5'b01000, 5'b00001, 1'b0}; // E193
      tbl[27] = '{5'b00110, 3'd2, 3'd6, 8'd8,  5'b00001, 5'b00001, 1'b0}; // E201
      tbl[28] = '{5'b11111, 3'd7, 3'd7, 8'd4,  5'b00001, 5'b00001, 1'b0}; // E205

      RST = 1'b1; BTN = '0; PWR_L = '0; PWR_R = '0;

      // Directed table
      do_reset();
      check("reset_mc1", 16'(MC1), 16'(5'b00001));
      check("reset_mc2", 16'(MC2), 16'(5'b00001));
      check("reset_busy", 16'(BUSY), 16'(0));
      for (int i = 0; i < 29; i++) begin
         BTN = tbl[i].btn; PWR_L = tbl[i].pl; PWR_R = tbl[i].pr;
         repeat (int'(tbl[i].cyc)) @(posedge CLK);
         @(negedge CLK);
         check($sformatf("vec%0d_mc1", i), 16'(MC1), 16'(tbl[i].mc1));
         check($sformatf("vec%0d_mc2", i), 16'(MC2), 16'(tbl[i].mc2));
         check($sformatf("vec%0d_busy", i), 16'(BUSY), 16'(tbl[i].busy));
      end

      // Asynchronous reset in the middle of a ramp-down
      do_reset();
      BTN = 5'b00100; PWR_L = 3'd5; PWR_R = 3'd7;
      repeat (17) @(posedge CLK);
      @(negedge CLK);
      check("pre_rst_mc1", 16'(MC1), 16'(5'b10000));
      BTN = 5'b00010;
      @(posedge CLK);
      @(negedge CLK);
      check("pre_rst_busy", 16'(BUSY), 16'(1));
      #2 RST = 1'b1;
      #1;
      check("async_rst_mc1", 16'(MC1), 16'(5'b00001));
      check("async_rst_mc2", 16'(MC2), 16'(5'b00001));
      check("async_rst_busy", 16'(BUSY), 16'(0));
      @(negedge CLK);
      BTN = '0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      check("post_rst_idle", 16'({MC1, MC2, BUSY}), 16'({5'b00001, 5'b00001, 1'b0}));
      BTN = 5'b00100;
      @(posedge CLK);
      @(negedge CLK);
      check("post_rst_press", 16'({MC1, MC2}), 16'({5'b00000, 5'b00000}));

      // Randomized run against the model
      pick[0] = 5'b00100; pick[1] = 5'b00010; pick[2] = 5'b01000; pick[3] = 5'b00001;
      pick[4] = 5'b10000; pick[5] = 5'b00000; pick[6] = 5'b11111; pick[7] = 5'b00110;
      do_reset();
      hold = '0;
      for (int c = 0; c < 3000; c++) begin
         check("rand_outputs", 16'({MC1, MC2, BUSY}), 16'(model_out()));
         if (hold == 0) begin
            BTN  = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : pick[$urandom_range(0, 7)];
            hold = 4'($urandom_range(1, 15));
         end else begin
            hold--;
         end
         if ($urandom_range(0, 19) == 0) PWR_L = 3'($urandom());
         if ($urandom_range(0, 19) == 0) PWR_R = 3'($urandom());
         model_step();
         @(posedge CLK);
         @(negedge CLK);
      end
      check("rand_final", 16'({MC1, MC2, BUSY}), 16'(model_out()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
